// File: rtl/mem_rw_sequencer.sv
// mem_rw_sequencer: pairs AW/W beats, round-robins one single-port byte
// memory between writes and reads, and pulses the B/R TX channel enables.
//
// state | meaning
// IDLE  | evaluate eligibility and grant write or read
// WR    | drive memory write strobe with held address/data
// WRESP | pulse b_en, release AW and W holds
// RD    | drive memory read strobe with held read address
// RCAP  | register memory read data into r_data
// RSEND | pulse r_en, release AR hold
module mem_rw_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              aw_new,
  input  logic [ADDR_W-1:0] aw_addr,
  output logic              aw_busy,
  input  logic              w_new,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_busy,
  input  logic              ar_new,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              ar_busy,
  output logic              b_en,
  input  logic              b_hold,
  output logic              r_en,
  output logic [DATA_W-1:0] r_data,
  input  logic              r_hold,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RD    = 3'd3,
    RCAP  = 3'd4,
    RSEND = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic              rr_last_wr;  // 1: last grant was a write, 0: read
  logic              aw_pend, w_pend, ar_pend;
  logic [ADDR_W-1:0] aw_q, ar_q;
  logic [DATA_W-1:0] w_q;
  logic              wr_ok, rd_ok;

  assign aw_busy = aw_pend;
  assign w_busy  = w_pend;
  assign ar_busy = ar_pend;

  assign wr_ok = aw_pend & w_pend & ~b_hold;
  assign rd_ok = ar_pend & ~r_hold;

  // State register and round-robin memory of the last granted side.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      rr_last_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WR)
        rr_last_wr <= 1'b1;
      else if (state == RD)
        rr_last_wr <= 1'b0;
    end
  end

  // Capture strobes into hold registers; a strobe while held is dropped and flagged.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      ar_q    <= '0;
      err     <= 1'b0;
    end else begin
      if (state == WRESP) begin
        aw_pend <= 1'b0;
        w_pend  <= 1'b0;
      end
      if (state == RSEND)
        ar_pend <= 1'b0;
      if (aw_new && !aw_pend) begin
        aw_pend <= 1'b1;
        aw_q    <= aw_addr;
      end
      if (w_new && !w_pend) begin
        w_pend <= 1'b1;
        w_q    <= w_data;
      end
      if (ar_new && !ar_pend) begin
        ar_pend <= 1'b1;
        ar_q    <= ar_addr;
      end
      if ((aw_new && aw_pend) || (w_new && w_pend) || (ar_new && ar_pend))
        err <= 1'b1;
    end
  end

  // Registered read beat, held until the next read capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      r_data <= '0;
    else if (state == RCAP)
      r_data <= mem_rdata;
  end

  // Next-state and memory/TX strobe decode.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    b_en      = 1'b0;
    r_en      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok && rd_ok)
          state_nxt = rr_last_wr ? RD : WR;
        else if (wr_ok)
          state_nxt = WR;
        else if (rd_ok)
          state_nxt = RD;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = aw_q;
        mem_wdata = w_q;
        state_nxt = WRESP;
      end
      WRESP: begin
        b_en      = 1'b1;
        state_nxt = IDLE;
      end
      RD: begin
        mem_re    = 1'b1;
        mem_addr  = ar_q;
        state_nxt = RCAP;
      end
      RCAP: begin
        state_nxt = RSEND;
      end
      RSEND: begin
        r_en      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_rw_sequencer.sv
// Bench for mem_rw_sequencer: directed scenarios plus random traffic, with a
// byte-array memory model and a scoreboard monitor decoupled from stimulus.
module tb_mem_rw_sequencer;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          aw_new, w_new, ar_new;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [DW-1:0] w_data;
  logic          aw_busy, w_busy, ar_busy;
  logic          b_en, b_hold, r_en, r_hold;
  logic [DW-1:0] r_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          err;

  mem_rw_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .aw_new(aw_new), .aw_addr(aw_addr), .aw_busy(aw_busy),
    .w_new(w_new), .w_data(w_data), .w_busy(w_busy),
    .ar_new(ar_new), .ar_addr(ar_addr), .ar_busy(ar_busy),
    .b_en(b_en), .b_hold(b_hold),
    .r_en(r_en), .r_data(r_data), .r_hold(r_hold),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge ACLK) cycle <= cycle + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [AW-1:0] aw_tb[$];
  logic [DW-1:0] w_tb[$];
  wr_t           wr_exp[$];
  logic [AW-1:0] rd_exp[$];
  logic [DW-1:0] r_exp[$];
  int            b_due[$];
  int            r_due[$];
  int            grant_log[$];   // 1 = write, 0 = read
  logic [7:0]    ref_mem[DEPTH];
  logic [7:0]    phys[DEPTH];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected or missing event, expected consistent event", nm);
  endfunction

  function automatic void pair();
    wr_t e;
    while (aw_tb.size() > 0 && w_tb.size() > 0) begin
      e.addr = aw_tb.pop_front();
      e.data = w_tb.pop_front();
      wr_exp.push_back(e);
    end
  endfunction

  function automatic void flush();
    aw_tb.delete(); w_tb.delete(); wr_exp.delete(); rd_exp.delete();
    r_exp.delete(); b_due.delete(); r_due.delete(); grant_log.delete();
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return AW'(DEPTH - 2);
      1: return AW'(DEPTH - 1);
      2: return AW'($urandom_range(0, 15));
      default: return AW'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  // Memory model: bytes base+i wrap modulo depth; read data one cycle after mem_re.
  always @(posedge ACLK) begin
    if (mem_we)
      for (int i = 0; i < NB; i++)
        phys[(int'(mem_addr) + i) % DEPTH] <= mem_wdata[8*i +: 8];
    if (mem_re)
      for (int i = 0; i < NB; i++)
        mem_rdata[8*i +: 8] <= phys[(int'(mem_addr) + i) % DEPTH];
  end

  // Scoreboard monitor.
  always @(negedge ACLK) begin : mon
    wr_t           e;
    logic [AW-1:0] ra;
    logic [DW-1:0] x;
    if (!ARESET) begin
      if (mem_we && mem_re) fail("we_and_re");
      if (mem_we) begin
        grant_log.push_back(1);
        if (wr_exp.size() == 0) fail("unexpected_write");
        else begin
          e = wr_exp.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e.addr));
          check("wr_data", 64'(mem_wdata), 64'(e.data));
          for (int i = 0; i < NB; i++)
            ref_mem[(int'(e.addr) + i) % DEPTH] = e.data[8*i +: 8];
        end
        b_due.push_back(cycle + 1);
      end
      if (mem_re) begin
        grant_log.push_back(0);
        if (rd_exp.size() == 0) fail("unexpected_read");
        else begin
          ra = rd_exp.pop_front();
          check("rd_addr", 64'(mem_addr), 64'(ra));
          for (int i = 0; i < NB; i++)
            x[8*i +: 8] = ref_mem[(int'(ra) + i) % DEPTH];
          r_exp.push_back(x);
        end
        r_due.push_back(cycle + 2);
      end
      if (!mem_we && !mem_re)
        check("mem_idle_zero", {20'd0, mem_addr, mem_wdata}, 64'd0);
      if (b_en) begin
        if (b_due.size() == 0) fail("unexpected_b_en");
        else check("b_latency", 64'(cycle), 64'(b_due.pop_front()));
      end
      if (r_en) begin
        if (r_due.size() == 0 || r_exp.size() == 0) fail("unexpected_r_en");
        else begin
          check("r_latency", 64'(cycle), 64'(r_due.pop_front()));
          check("r_data", 64'(r_data), 64'(r_exp.pop_front()));
        end
      end
    end
  end

  task automatic drive(input bit sa, input bit sw, input bit sr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] ra, input bit push_aw = 1'b1);
    aw_new = sa; aw_addr = a;
    w_new  = sw; w_data  = d;
    ar_new = sr; ar_addr = ra;
    if (sa && push_aw) aw_tb.push_back(a);
    if (sw) w_tb.push_back(d);
    if (sr) rd_exp.push_back(ra);
    pair();
    @(negedge ACLK);
    aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
    b_hold = 1'b0; r_hold = 1'b0;
    flush();
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ctl"}, 64'({aw_busy, w_busy, ar_busy, b_en, r_en, mem_we, mem_re, err}), 64'd0);
    check({tag, "_r_data"}, 64'(r_data), 64'd0);
    check({tag, "_mem"}, {20'd0, mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic wait_b(input int max, input string nm);
    int n = 0;
    while (!b_en && n < max) begin @(negedge ACLK); n++; end
    if (!b_en) fail(nm);
  endtask

  task automatic wait_r(input int max, input string nm);
    int n = 0;
    while (!r_en && n < max) begin @(negedge ACLK); n++; end
    if (!r_en) fail(nm);
  endtask

  task automatic wait_grant(input int max, input string nm);
    int n = 0;
    while (!(mem_we || mem_re) && n < max) begin @(negedge ACLK); n++; end
    if (!(mem_we || mem_re)) fail(nm);
  endtask

  task automatic drain(input int max, input string nm);
    int n = 0;
    while ((aw_busy || w_busy || ar_busy) && n < max) begin @(negedge ACLK); n++; end
    if (aw_busy || w_busy || ar_busy) fail(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    aw_addr = '0; w_data = '0; ar_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'($urandom);
      phys[i]    = ref_mem[i];
    end
    ARESET = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge ACLK);
    do_reset();
    check_zero("reset_release");

    // AW one cycle before W.
    drive(1, 0, 0, 12'h010, '0, '0);
    drive(0, 1, 0, '0, 32'hDEADBEEF, '0);
    wait_b(10, "t1_b_timeout");
    @(negedge ACLK);
    check("t1_busy_after_b", 64'({aw_busy, w_busy}), 64'd0);

    // W before AW with a gap, then read back.
    drive(0, 1, 0, '0, 32'hDEADBEEF, '0);
    repeat (3) @(negedge ACLK);
    drive(1, 0, 0, 12'h010, '0, '0);
    wait_b(10, "t2_b_timeout");
    @(negedge ACLK);
    drive(0, 0, 1, '0, '0, 12'h010);
    wait_r(10, "t2_r_timeout");
    check("t2_r_data", 64'(r_data), 64'hDEADBEEF);

    // Simultaneous AW+W+AR after reset, then alternation under both-eligible.
    do_reset();
    drive(1, 1, 1, 12'h100, 32'($urandom), 12'h100);
    for (int k = 0; k < 8; k++) begin
      wait_grant(20, "t3_grant_timeout");
      b_hold = 1'b1; r_hold = 1'b1;
      if (k < 7) begin
        n = 0;
        while (aw_busy && ar_busy && n < 20) begin @(negedge ACLK); n++; end
        if (!aw_busy) drive(1, 1, 0, rand_addr(), 32'($urandom), '0);
        else          drive(0, 0, 1, '0, '0, rand_addr());
      end
      b_hold = 1'b0; r_hold = 1'b0;
      @(negedge ACLK);
    end
    drain(50, "t3_drain");
    check("t3_grant_count_ge8", 64'(grant_log.size() >= 8), 64'd1);
    if (grant_log.size() >= 8)
      for (int i = 0; i < 8; i++)
        check($sformatf("t3_grant_%0d", i), 64'(grant_log[i]), 64'((i % 2) == 0));

    // b_hold blocks only the write; read proceeds.
    grant_log.delete();
    b_hold = 1'b1;
    drive(1, 1, 1, 12'h020, 32'($urandom), 12'h020);
    for (int i = 0; i < 10; i++) begin
      check("t4_b_en_held", 64'(b_en), 64'd0);
      @(negedge ACLK);
    end
    check("t4_grant_count", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() >= 1) check("t4_first_is_read", 64'(grant_log[0]), 64'd0);
    check("t4_err", 64'(err), 64'd0);
    b_hold = 1'b0;
    wait_b(10, "t4_b_timeout");
    check("t4_err_after", 64'(err), 64'd0);
    @(negedge ACLK);

    // Double AW strobe: error, second address ignored.
    drive(1, 0, 0, 12'h200, '0, '0);
    drive(1, 0, 0, 12'h300, '0, '0, 1'b0);
    check("t5_err_set", 64'(err), 64'd1);
    drive(0, 1, 0, '0, 32'h12345678, '0);
    wait_b(10, "t5_b_timeout");
    repeat (5) @(negedge ACLK);
    check("t5_err_sticky", 64'(err), 64'd1);
    do_reset();
    check("t5_err_cleared", 64'(err), 64'd0);

    // Reset during RCAP drops the read.
    drive(0, 0, 1, '0, '0, 12'h123);
    n = 0;
    while (!mem_re && n < 10) begin @(negedge ACLK); n++; end
    if (!mem_re) fail("t6_rd_timeout");
    @(negedge ACLK);
    ARESET = 1'b1;
    flush();
    #1;
    check_zero("t6_reset");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t6_no_r_en", 64'(r_en), 64'd0);
      @(negedge ACLK);
    end
    check("t6_ar_busy", 64'(ar_busy), 64'd0);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      b_hold = ($urandom_range(0, 9) < 2);
      r_hold = ($urandom_range(0, 9) < 2);
      aw_new = !aw_busy && ($urandom_range(0, 9) < 3);
      w_new  = !w_busy  && ($urandom_range(0, 9) < 3);
      ar_new = !ar_busy && ($urandom_range(0, 9) < 3);
      aw_addr = rand_addr();
      w_data  = 32'($urandom);
      ar_addr = rand_addr();
      if (aw_new) aw_tb.push_back(aw_addr);
      if (w_new)  w_tb.push_back(w_data);
      if (ar_new) rd_exp.push_back(ar_addr);
      pair();
      @(negedge ACLK);
    end
    aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
    b_hold = 1'b0; r_hold = 1'b0;
    // Orphan half-pairs cannot complete; give them partners so the bench drains.
    if (aw_busy && !w_busy) drive(0, 1, 0, '0, 32'($urandom), '0);
    else if (w_busy && !aw_busy) drive(1, 0, 0, rand_addr(), '0, '0);
    drain(100, "rand_drain");
    repeat (3) @(negedge ACLK);
    check("rand_wr_exp_empty", 64'(wr_exp.size()), 64'd0);
    check("rand_rd_exp_empty", 64'(rd_exp.size()), 64'd0);
    check("rand_r_exp_empty", 64'(r_exp.size()), 64'd0);
    check("rand_b_due_empty", 64'(b_due.size()), 64'd0);
    check("rand_r_due_empty", 64'(r_due.size()), 64'd0);
    check("rand_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rw_sequencer.md
Name: mem_rw_sequencer

Overview:
- Controller between the subordinate's RX/TX channel wrappers (AW, W, AR, B, R) and a single-port byte memory.
- Pairs AW and W beats that arrive in either order, arbitrates the one memory port between write and read with round-robin, and sequences memory accesses.
- Issues one-cycle tx_en pulses to the B and R TX channels.
- Replaces ad-hoc combinational read muxing with a registered, sequenced read path.

Parameters:
- ADDR_W, 12, memory address width in bytes (memory depth 2**ADDR_W).
- DATA_W, 32, beat width in bits; must be a multiple of 8.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- aw_new  in  1  AW RX new-data strobe (1 cycle).
- aw_addr  in  ADDR_W  AW address, valid with aw_new.
- aw_busy  out  1  hold to AW RX channel.
- w_new  in  1  W RX new-data strobe.
- w_data  in  DATA_W  write beat, valid with w_new.
- w_busy  out  1  hold to W RX channel.
- ar_new  in  1  AR RX new-data strobe.
- ar_addr  in  ADDR_W  read address, valid with ar_new.
- ar_busy  out  1  hold to AR RX channel.
- b_en  out  1  one-cycle tx_en pulse to B TX channel (response OKAY).
- b_hold  in  1  B TX channel busy.
- r_en  out  1  one-cycle tx_en pulse to R TX channel.
- r_data  out  DATA_W  registered read beat, stable from r_en until the next read completes.
- r_hold  in  1  R TX channel busy.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory base byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_re.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, ARESET=1):
  - All pending flags cleared; state=IDLE; rr_last=READ, so write wins the first tie.
  - All outputs 0, including r_data and err.
  - Reset during any state drops in-flight work; no b_en or r_en is issued afterwards for it.
- Capture registers:
  - aw_new: aw_pend<=1, aw_q<=aw_addr.
  - w_new: w_pend<=1, w_q<=w_data.
  - ar_new: ar_pend<=1, ar_q<=ar_addr.
  - aw_busy=aw_pend, w_busy=w_pend, ar_busy=ar_pend (combinational from flags).
  - A strobe arriving while its pend flag is set is ignored (the held data is kept) and sets err; err clears only on reset.
- Eligibility (evaluated in IDLE only):
  - wr_ok = aw_pend & w_pend & ~b_hold.
  - rd_ok = ar_pend & ~r_hold.
- State machine:
  - IDLE: both eligible -> grant the side opposite rr_last; one eligible -> grant it; none -> stay.
  - WR (1 cycle): mem_we=1, mem_addr=aw_q, mem_wdata=w_q; rr_last<=WRITE; next state WRESP.
  - WRESP (1 cycle): b_en=1; aw_pend<=0, w_pend<=0; next state IDLE.
  - RD (1 cycle): mem_re=1, mem_addr=ar_q; rr_last<=READ; next state RCAP.
  - RCAP (1 cycle): r_data<=mem_rdata; next state RSEND.
  - RSEND (1 cycle): r_en=1; ar_pend<=0; next state IDLE.
- Latency:
  - Write: IDLE grant -> mem_we on the next cycle -> b_en on the cycle after.
  - Read: IDLE grant -> mem_re -> capture -> r_en, three cycles after leaving IDLE.
  - Minimum turnaround: 3 cycles per write, 4 per read, including the IDLE cycle.
- Strobe timing:
  - Busy flags stay high through WRESP/RSEND; a new strobe in that cycle is an error.
  - The channel may present a new strobe the cycle after the flag clears.
- Address and memory:
  - mem_addr carries the unaligned base address; the memory services bytes base+i modulo 2**ADDR_W, i=0..DATA_W/8-1.
  - When not in WR/RD: mem_we, mem_re, mem_addr and mem_wdata are driven 0.
- Ordering:
  - No read-after-write hazard: the memory port is serialized.
  - A read granted after a write observes that write.
- Fairness: under continuous both-eligible, grants strictly alternate W,R,W,R; neither side starves.
- Hold during IDLE: b_hold or r_hold only blocks eligibility; a pending request waits indefinitely without error.

Test Plan:
- Reset, then AW addr=0x010 one cycle before W data=0xDEADBEEF -> mem_we 1 cycle with addr 0x010, data 0xDEADBEEF; b_en 1 cycle later; aw_busy/w_busy drop after b_en.
- W before AW (3-cycle gap), then AR 0x010 -> write completes first; r_data=0xDEADBEEF with r_en pulse 3 cycles after the RD grant.
- AW+W+AR pending in the same cycle after reset -> write granted first; continuous traffic then alternates W,R,W,R (check 8 grants).
- b_hold=1 for 10 cycles with a write pending and a read pending -> read proceeds; write waits, no err; b_en follows b_hold release.
- aw_new asserted twice without an intervening b_en -> err=1 sticky; second address ignored (mem_addr = first address).
- ARESET asserted during RCAP -> all outputs 0 immediately; no r_en after release; ar_busy=0.
